// File: rtl/ldpc_pkg.sv
// Shared LDPC VNP types and arithmetic helpers.
// FSM state encoding, sign extension and saturation.
package ldpc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } vnp_state_e;

  // Sign-extend the low w bits of x to 32 bits.
  function automatic logic signed [31:0] sext32(
    input logic [31:0] x,
    input int          w
  );
    logic signed [31:0] t;
    t = signed'(x << (32 - w));
    return t >>> (32 - w);
  endfunction

  // Clamp x to the w-bit two's complement range.
  function automatic logic signed [31:0] sat32(
    input logic signed [31:0] x,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/ldpc_vnp_bank.sv
// One VNP accumulator bank: sums channel + DV messages,
// buffers them, and produces saturated total and extrinsics.
// Ports: ld_i/k_i/din_i/src_i load slot k; sel_k_i picks the
// extrinsic on ext_o; tot_o/hd_o give the total and its sign.
module ldpc_vnp_bank
  import ldpc_pkg::*;
#(
  parameter int DV    = 3,
  parameter int MW    = 8,
  parameter int ACC_W = 10,
  parameter int KW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_i,
  input  logic [KW-1:0] k_i,
  input  logic [MW-1:0] din_i,
  input  logic [MW-1:0] src_i,
  input  logic [KW-1:0] sel_k_i,
  output logic [MW-1:0] tot_o,
  output logic [MW-1:0] ext_o,
  output logic          hd_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] dx;
  logic signed [ACC_W-1:0] sx;
  logic signed [ACC_W-1:0] mx;
  logic signed [ACC_W-1:0] ext_w;
  logic [MW-1:0]           mbuf_q [DV];

  assign dx = ACC_W'(sext32(32'(din_i), MW));
  assign sx = ACC_W'(sext32(32'(src_i), MW));
  assign mx = ACC_W'(sext32(32'(mbuf_q[sel_k_i]), MW));

  // Channel LLR is folded in alongside message 1.
  always_comb begin
    acc_d = acc_q;
    if (ld_i) begin
      unique case (1'b1)
        k_i == '0:     acc_d = dx;
        k_i == KW'(1): acc_d = acc_q + dx + sx;
        default:       acc_d = acc_q + dx;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      for (int i = 0; i < DV; i++) mbuf_q[i] <= '0;
    end else begin
      acc_q <= acc_d;
      if (ld_i) mbuf_q[k_i] <= din_i;
    end
  end

  assign ext_w = acc_q - mx;
  assign tot_o = MW'(sat32(32'(acc_q), MW));
  assign ext_o = MW'(sat32(32'(ext_w), MW));
  assign hd_o  = acc_q[ACC_W-1];

endmodule

// File: rtl/ldpc_vnp_gen.sv
// Parametrised LDPC variable-node processor, one half-iteration
// per start. Ports: start/last_iter/busy/done handshake; src_*
// channel RAM, mess_* message RAM, res_* result RAM.
module ldpc_vnp_gen
  import ldpc_pkg::*;
#(
  parameter int N_VN = 8,
  parameter int DV   = 3,
  parameter int MW   = 8,
  parameter int VA_W = $clog2(N_VN),
  parameter int MA_W = $clog2(N_VN * DV)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            last_iter,
  output logic            busy,
  output logic            done,
  output logic [VA_W-1:0] src_addr,
  input  logic [MW-1:0]   src_din,
  output logic [MA_W-1:0] mess_raddr,
  input  logic [MW-1:0]   mess_din,
  output logic            mess_we,
  output logic [MA_W-1:0] mess_waddr,
  output logic [MW-1:0]   mess_dout,
  output logic            res_we,
  output logic [VA_W-1:0] res_addr,
  output logic [MW-1:0]   res_llr,
  output logic            res_hd
);

  localparam int ACC_W = MW + $clog2(DV + 1);
  localparam int KW    = $clog2(DV);
  localparam logic [KW-1:0]   K_LAST = KW'(DV - 1);
  localparam logic [VA_W-1:0] V_LAST = VA_W'(N_VN - 1);
  localparam logic [MA_W-1:0] A_LAST = MA_W'(N_VN * DV - 1);

  vnp_state_e state_q;
  vnp_state_e state_d;
  logic            li_q;
  logic [VA_W-1:0] rd_v_q;
  logic [KW-1:0]   rd_k_q;
  logic [MA_W-1:0] rd_a_q;
  logic            cap_vld_q;
  logic [KW-1:0]   cap_k_q;
  logic            cap_b_q;
  logic            wr_vld_q;
  logic [VA_W-1:0] wr_v_q;
  logic [KW-1:0]   wr_k_q;
  logic [MA_W-1:0] wr_a_q;
  logic rd_last;
  logic wr_last;
  logic wr_start;
  logic wsel;
  logic [MW-1:0] tot0, tot1, ext0, ext1;
  logic hd0, hd1;

  assign rd_last  = rd_v_q == V_LAST && rd_k_q == K_LAST;
  assign wr_last  = wr_vld_q && wr_a_q == A_LAST;
  assign wr_start = cap_vld_q && cap_k_q == K_LAST;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (rd_last) state_d = S_FLUSH;
      S_FLUSH: if (wr_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      li_q    <= 1'b0;
      rd_v_q  <= '0;
      rd_k_q  <= '0;
      rd_a_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) li_q <= last_iter;
      if (state_q == S_RUN) begin
        if (rd_last) begin
          rd_v_q <= '0;
          rd_k_q <= '0;
          rd_a_q <= '0;
        end else begin
          rd_a_q <= rd_a_q + MA_W'(1);
          if (rd_k_q == K_LAST) begin
            rd_k_q <= '0;
            rd_v_q <= rd_v_q + VA_W'(1);
          end else begin
            rd_k_q <= rd_k_q + KW'(1);
          end
        end
      end
    end
  end

  // Read data returns one cycle after the address.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_vld_q <= 1'b0;
      cap_k_q   <= '0;
      cap_b_q   <= 1'b0;
    end else begin
      cap_vld_q <= state_q == S_RUN;
      cap_k_q   <= rd_k_q;
      cap_b_q   <= rd_v_q[0];
    end
  end

  // Node writes are back to back: node v+1 finishes loading
  // exactly as node v issues its last extrinsic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_q <= 1'b0;
      wr_v_q   <= '0;
      wr_k_q   <= '0;
      wr_a_q   <= '0;
    end else if (wr_vld_q) begin
      if (wr_last) begin
        wr_vld_q <= 1'b0;
        wr_v_q   <= '0;
        wr_k_q   <= '0;
        wr_a_q   <= '0;
      end else begin
        wr_a_q <= wr_a_q + MA_W'(1);
        if (wr_k_q == K_LAST) begin
          wr_k_q <= '0;
          wr_v_q <= wr_v_q + VA_W'(1);
        end else begin
          wr_k_q <= wr_k_q + KW'(1);
        end
      end
    end else if (wr_start) begin
      wr_vld_q <= 1'b1;
      wr_v_q   <= '0;
      wr_k_q   <= '0;
      wr_a_q   <= '0;
    end
  end

  ldpc_vnp_bank #(
    .DV(DV), .MW(MW), .ACC_W(ACC_W), .KW(KW)
  ) u_bank0 (
    .clk(clk), .rst(rst),
    .ld_i(cap_vld_q && !cap_b_q),
    .k_i(cap_k_q), .din_i(mess_din), .src_i(src_din),
    .sel_k_i(wr_k_q),
    .tot_o(tot0), .ext_o(ext0), .hd_o(hd0)
  );

  ldpc_vnp_bank #(
    .DV(DV), .MW(MW), .ACC_W(ACC_W), .KW(KW)
  ) u_bank1 (
    .clk(clk), .rst(rst),
    .ld_i(cap_vld_q && cap_b_q),
    .k_i(cap_k_q), .din_i(mess_din), .src_i(src_din),
    .sel_k_i(wr_k_q),
    .tot_o(tot1), .ext_o(ext1), .hd_o(hd1)
  );

  assign wsel       = wr_v_q[0];
  assign busy       = state_q == S_RUN || state_q == S_FLUSH;
  assign done       = state_q == S_DONE;
  assign src_addr   = rd_v_q;
  assign mess_raddr = rd_a_q;
  assign mess_we    = wr_vld_q && !li_q;
  assign mess_waddr = wr_a_q;
  assign mess_dout  = mess_we ? (wsel ? ext1 : ext0) : '0;
  assign res_we     = wr_vld_q && wr_k_q == '0;
  assign res_addr   = wr_v_q;
  assign res_llr    = res_we ? (wsel ? tot1 : tot0) : '0;
  assign res_hd     = res_we && (wsel ? hd1 : hd0);

endmodule

// File: tb/tb_ldpc_vnp_gen.sv
// Scoreboard bench for ldpc_vnp_gen: a small instance (2x3x8)
// with directed vectors and a 5x4x6 instance with random LLRs.
module tb_ldpc_vnp_gen;

  typedef struct {
    int addr;
    int data;
    bit hd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: N_VN=2, DV=3, MW=8
  logic       start_a = 1'b0, last_iter_a = 1'b0;
  logic       busy_a, done_a, mess_we_a, res_we_a, res_hd_a;
  logic [0:0] src_addr_a, res_addr_a;
  logic [2:0] mess_raddr_a, mess_waddr_a;
  logic [7:0] src_din_a, mess_din_a, mess_dout_a, res_llr_a;
  logic [7:0] cha_mem [2];
  logic [7:0] msga_mem [6];
  int   ch_a [2];
  int   msg_a [6];
  exp_t qa_res[$], qa_mess[$];
  int   qa_done[$];

  ldpc_vnp_gen #(.N_VN(2), .DV(3), .MW(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .last_iter(last_iter_a), .busy(busy_a), .done(done_a),
    .src_addr(src_addr_a), .src_din(src_din_a),
    .mess_raddr(mess_raddr_a), .mess_din(mess_din_a),
    .mess_we(mess_we_a), .mess_waddr(mess_waddr_a),
    .mess_dout(mess_dout_a), .res_we(res_we_a),
    .res_addr(res_addr_a), .res_llr(res_llr_a),
    .res_hd(res_hd_a)
  );

  always @(posedge clk) begin
    src_din_a  <= cha_mem[src_addr_a];
    mess_din_a <= msga_mem[mess_raddr_a];
  end

  // Instance B: N_VN=5, DV=4, MW=6
  logic       start_b = 1'b0, last_iter_b = 1'b0;
  logic       busy_b, done_b, mess_we_b, res_we_b, res_hd_b;
  logic [2:0] src_addr_b, res_addr_b;
  logic [4:0] mess_raddr_b, mess_waddr_b;
  logic [5:0] src_din_b, mess_din_b, mess_dout_b, res_llr_b;
  logic [5:0] chb_mem [5];
  logic [5:0] msgb_mem [20];
  exp_t qb_res[$], qb_mess[$];
  int   qb_done[$];

  ldpc_vnp_gen #(.N_VN(5), .DV(4), .MW(6)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .last_iter(last_iter_b), .busy(busy_b), .done(done_b),
    .src_addr(src_addr_b), .src_din(src_din_b),
    .mess_raddr(mess_raddr_b), .mess_din(mess_din_b),
    .mess_we(mess_we_b), .mess_waddr(mess_waddr_b),
    .mess_dout(mess_dout_b), .res_we(res_we_b),
    .res_addr(res_addr_b), .res_llr(res_llr_b),
    .res_hd(res_hd_b)
  );

  always @(posedge clk) begin
    src_din_b  <= chb_mem[src_addr_b];
    mess_din_b <= msgb_mem[mess_raddr_b];
  end

  function automatic int satv(input int x, input int mw);
    int hi, lo;
    hi = (1 << (mw - 1)) - 1;
    lo = -(1 << (mw - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)",
               name, act, req, cyc);
    end
  endtask

  function automatic int outs_a();
    return int'({busy_a, done_a, mess_we_a, res_we_a,
                 src_addr_a, mess_raddr_a, mess_waddr_a,
                 mess_dout_a, res_addr_a, res_llr_a, res_hd_a});
  endfunction

  // Monitor A
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (res_we_a) begin
      if (qa_res.size() == 0) chk("A unexpected res_we", 1, 0);
      else begin
        e = qa_res.pop_front();
        chk("A res_addr", int'(res_addr_a), e.addr);
        chk("A res_llr", int'($signed(res_llr_a)), e.data);
        chk("A res_hd", int'(res_hd_a), int'(e.hd));
      end
    end
    if (mess_we_a) begin
      if (qa_mess.size() == 0) chk("A unexpected mess_we", 1, 0);
      else begin
        e = qa_mess.pop_front();
        chk("A mess_waddr", int'(mess_waddr_a), e.addr);
        chk("A mess_dout", int'($signed(mess_dout_a)), e.data);
      end
    end
    if (done_a) begin
      if (qa_done.size() == 0) chk("A unexpected done", 1, 0);
      else begin
        chk("A done cycle", cyc, qa_done.pop_front());
        chk("A busy at done", int'(busy_a), 0);
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (res_we_b) begin
      if (qb_res.size() == 0) chk("B unexpected res_we", 1, 0);
      else begin
        e = qb_res.pop_front();
        chk("B res_addr", int'(res_addr_b), e.addr);
        chk("B res_llr", int'($signed(res_llr_b)), e.data);
        chk("B res_hd", int'(res_hd_b), int'(e.hd));
      end
    end
    if (mess_we_b) begin
      if (qb_mess.size() == 0) chk("B unexpected mess_we", 1, 0);
      else begin
        e = qb_mess.pop_front();
        chk("B mess_waddr", int'(mess_waddr_b), e.addr);
        chk("B mess_dout", int'($signed(mess_dout_b)), e.data);
      end
    end
    if (done_b) begin
      if (qb_done.size() == 0) chk("B unexpected done", 1, 0);
      else begin
        chk("B done cycle", cyc, qb_done.pop_front());
        chk("B busy at done", int'(busy_b), 0);
      end
    end
  end

  task automatic set_a(input int c0, input int c1,
                       input int m0, input int m1, input int m2,
                       input int m3, input int m4, input int m5);
    ch_a[0] = c0; ch_a[1] = c1;
    msg_a[0] = m0; msg_a[1] = m1; msg_a[2] = m2;
    msg_a[3] = m3; msg_a[4] = m4; msg_a[5] = m5;
  endtask

  // Called at a negedge. rst_at >= 0 aborts the run that many
  // cycles after t0.
  task automatic run_a(input bit li, input bit poke,
                       input int rst_at);
    int tot;
    int sc;
    for (int v = 0; v < 2; v++) begin
      cha_mem[v] = 8'(ch_a[v]);
      tot = ch_a[v];
      for (int k = 0; k < 3; k++) begin
        msga_mem[v*3+k] = 8'(msg_a[v*3+k]);
        tot += msg_a[v*3+k];
      end
      qa_res.push_back('{addr: v, data: satv(tot, 8),
                         hd: (tot < 0)});
      if (!li)
        for (int k = 0; k < 3; k++)
          qa_mess.push_back('{addr: v*3+k,
                              data: satv(tot - msg_a[v*3+k], 8),
                              hd: 1'b0});
    end
    start_a = 1'b1;
    last_iter_a = li;
    sc = cyc;
    qa_done.push_back(sc + 1 + 10);
    @(negedge clk);
    start_a = 1'b0;
    last_iter_a = ~li;
    chk("A busy at t0", int'(busy_a), 1);
    if (poke) begin
      repeat (2) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    if (rst_at >= 0) begin
      repeat (rst_at) @(negedge clk);
      #1;
      qa_res.delete();
      qa_mess.delete();
      qa_done.delete();
      rst = 1'b1;
      @(negedge clk);
      chk("A outputs after mid-run reset", outs_a(), 0);
      rst = 1'b0;
      repeat (15) @(negedge clk);
    end else begin
      repeat (20) @(negedge clk);
    end
    chk("A res queue drained", qa_res.size(), 0);
    chk("A mess queue drained", qa_mess.size(), 0);
    chk("A done queue drained", qa_done.size(), 0);
  endtask

  task automatic run_b();
    int ch[5];
    int m[20];
    int tot;
    int sc;
    for (int v = 0; v < 5; v++) begin
      ch[v] = int'($urandom_range(63)) - 32;
      chb_mem[v] = 6'(ch[v]);
      tot = ch[v];
      for (int k = 0; k < 4; k++) begin
        m[v*4+k] = int'($urandom_range(63)) - 32;
        msgb_mem[v*4+k] = 6'(m[v*4+k]);
        tot += m[v*4+k];
      end
      qb_res.push_back('{addr: v, data: satv(tot, 6),
                         hd: (tot < 0)});
      for (int k = 0; k < 4; k++)
        qb_mess.push_back('{addr: v*4+k,
                            data: satv(tot - m[v*4+k], 6),
                            hd: 1'b0});
    end
    start_b = 1'b1;
    sc = cyc;
    qb_done.push_back(sc + 1 + 25);
    @(negedge clk);
    start_b = 1'b0;
    chk("B busy at t0", int'(busy_b), 1);
    repeat (35) @(negedge clk);
    chk("B res queue drained", qb_res.size(), 0);
    chk("B mess queue drained", qb_mess.size(), 0);
    chk("B done queue drained", qb_done.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) cha_mem[i] = '0;
    for (int i = 0; i < 6; i++) msga_mem[i] = '0;
    for (int i = 0; i < 5; i++) chb_mem[i] = '0;
    for (int i = 0; i < 20; i++) msgb_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("A outputs in reset", outs_a(), 0);
    chk("B busy in reset", int'(busy_b), 0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal
    set_a(5, 5, 10, 10, 10, 10, 10, 10);
    run_a(1'b0, 1'b0, -1);
    // Positive saturation
    set_a(100, 100, 100, 100, 100, 100, 100, 100);
    run_a(1'b0, 1'b0, -1);
    // Negative saturation and mixed signs
    set_a(-100, -2, -100, -100, -100, 20, -30, 5);
    run_a(1'b0, 1'b0, -1);
    // Last iteration with a start pulsed while busy
    set_a(5, 5, 10, 10, 10, 10, 10, 10);
    run_a(1'b1, 1'b1, -1);
    // Reset in the middle of a run, then a clean rerun
    run_a(1'b0, 1'b0, 4);
    run_a(1'b0, 1'b0, -1);
    // Larger parameter set, random LLRs
    for (int r = 0; r < 3; r++) run_b();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ldpc_vnp_gen.md
Name: ldpc_vnp_gen

Overview:
Parametrised LDPC variable-node processor, the successor to the fixed 8-node, degree-3 VNP. It runs one variable-node half-iteration. For each node it reads the channel LLR and DV check-to-variable messages. It writes DV saturated extrinsic variable-to-check messages back to message memory, and writes the node's saturated a-posteriori LLR plus its hard decision to result memory. It sits between the channel/message/result RAMs and the iteration controller, alternating with the CNP, and uses a start/busy/done handshake.

Parameters:
N_VN, 8, number of variable nodes (>=2)
DV, 3, column degree / messages per node (>=2)
MW, 8, message and LLR width, two's complement
VA_W, $clog2(N_VN), source/result address width
MA_W, $clog2(N_VN*DV), message address width
ACC_W, MW+$clog2(DV+1), accumulator width (local constant, not overridable)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle request to run one half-iteration
last_iter  in  1  sampled with start; 1 = suppress message writes
busy  out  1  high from the first RUN cycle until done
done  out  1  one-cycle pulse when all writes have been issued
src_addr  out  VA_W  channel LLR RAM read address
src_din  in  MW  channel LLR, valid 1 cycle after address
mess_raddr  out  MA_W  message RAM read address
mess_din  in  MW  message read data, valid 1 cycle after address
mess_we  out  1  message write enable
mess_waddr  out  MA_W  message write address
mess_dout  out  MW  extrinsic message
res_we  out  1  result write enable
res_addr  out  VA_W  result address (node index)
res_llr  out  MW  saturated total LLR
res_hd  out  1  hard decision, sign bit of the unsaturated total

Behaviour:
- Reset: FSM goes to IDLE; busy, done, mess_we and res_we are 0; every address and data output is 0; accumulators and buffers are cleared. Reset asserted mid-RUN aborts the run at once, with no further writes and no done pulse.
- FSM states: IDLE -> RUN on start. RUN -> FLUSH after the last read. FLUSH -> DONE after the last write. DONE lasts 1 cycle with done=1, then returns to IDLE.
- start while not IDLE is ignored. last_iter is latched at start.
- Timing: start is sampled at edge E. The first RUN cycle is t0 = E+1. Read slot T(v,k) = t0 + v*DV + k, for v in 0..N_VN-1 and k in 0..DV-1.
- Reads at T(v,k): mess_raddr = v*DV+k. src_addr = v, held for the node's slot. src_din is used with the k=1 data. Message data for slot k is captured at T(v,k)+1.
- Accumulation: sign-extend every operand to ACC_W. The total is the channel LLR plus the DV messages. Two accumulator and message-buffer banks are selected by v[0]. This gives one node per DV cycles, with node v writing while node v+1 reads.
- Result write: at T(v,DV-1)+2, res_we=1, res_addr=v, res_llr = sat(total), res_hd = total[ACC_W-1]. This happens every run, including the last iteration.
- Message write: at T(v,k)+DV+1, mess_we = !last_iter_latched, mess_waddr = v*DV+k, mess_dout = sat(total - msg_k). The subtraction is done in ACC_W bits.
- sat(): clamp to [-2^(MW-1), 2^(MW-1)-1], otherwise truncate to MW bits.
- The last write is at t0 + (N_VN+1)*DV. done pulses at t0 + (N_VN+1)*DV + 1, which is also the cycle busy drops.
- No address ever reaches N_VN*DV or N_VN. All enables are 0 outside the defined slots.

Decomposition:
- Package ldpc_pkg holds: the sat() function parameterised on ACC_W/MW, the sign-extension helper, and the FSM state enum (IDLE, RUN, FLUSH, DONE).
- One sub-module: ldpc_vnp_bank, a single accumulator plus a DV-entry message buffer with extrinsic and saturation output, instantiated twice for ping-pong.

Test Plan:
Defaults in scenarios 1–4 are N_VN=2, DV=3, MW=8.
1. Nominal: all messages 10, channel 5, last_iter=0 -> each node gives res_llr=35, res_hd=0, all 6 mess_dout=25. mess_waddr sequence is 0..5. done pulses at t0+10.
2. Positive saturation: messages 100, channel 100 -> total 400, res_llr=127. Extrinsic 300 gives mess_dout=127, res_hd=0.
3. Negative saturation and mixed values: messages -100 and channel -100 -> res_llr=-128, mess_dout=-128, res_hd=1. Node 1 with messages {20,-30,5} and channel -2 -> total -7, res_hd=1, mess_dout {-27,23,-12}.
4. last_iter=1 -> mess_we stays 0 for the whole run, res_we pulses exactly twice with correct data, done timing is unchanged. A start pulsed while busy is ignored.
5. rst asserted at t0+4 -> the cycle after, busy=0 and all enables are 0, with no done pulse. A fresh start then gives results identical to scenario 1.
6. Parameter sweep with N_VN=5, DV=4, MW=6 and random LLRs against a reference model -> bit-exact results, with done at t0+25.
